// File: rtl/ysyx_25030093_mem_arbiter.sv
// ysyx_25030093_mem_arbiter
// Shares one SRAM read port (AXI-lite style AR/R channels) between the
// instruction fetch unit (IFU) and the load/store unit (LSU).
// Only one transaction (one AR beat plus one R beat) is ever outstanding.
// When both masters request at the same time, they are served in round-robin order.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ifu_* / lsu_*         master-side read address and read data channels
//   sram_*                slave-side read address and read data channels
//   grant                 one-hot current owner (bit0 IFU, bit1 LSU), 00 when idle
module ysyx_25030093_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic              ifu_arvalid,
    output logic              ifu_arready,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_rvalid,
    input  logic              ifu_rready,
    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic              lsu_arvalid,
    output logic              lsu_arready,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_rvalid,
    input  logic              lsu_rready,
    output logic [ADDR_W-1:0] sram_araddr,
    output logic              sram_arvalid,
    input  logic              sram_arready,
    input  logic [DATA_W-1:0] sram_rdata,
    input  logic              sram_rvalid,
    output logic              sram_rready,
    output logic [1:0]        grant
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } state_e;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [1:0]  grant_q, grant_d;

    logic              own_arvalid_s;
    logic [ADDR_W-1:0] own_araddr_s;
    logic              own_rready_s;
    logic              in_ar_s;
    logic              in_r_s;
    logic              ar_fire_s;
    logic              r_fire_s;

    // Round-robin pick: on a tie, the master that was not served last wins.
    function automatic logic rr_pick(input logic ifu_req, input logic lsu_req,
                                     input logic last_served);
        logic pick;
        if (ifu_req && lsu_req) begin
            pick = ~last_served;
        end else if (lsu_req) begin
            pick = OWN_LSU;
        end else begin
            pick = OWN_IFU;
        end
        return pick;
    endfunction

    // Select the current owner's request-side signals.
    always_comb begin
        if (owner_q == OWN_LSU) begin
            own_arvalid_s = lsu_arvalid;
            own_araddr_s  = lsu_araddr;
            own_rready_s  = lsu_rready;
        end else begin
            own_arvalid_s = ifu_arvalid;
            own_araddr_s  = ifu_araddr;
            own_rready_s  = ifu_rready;
        end
    end

    assign in_ar_s   = (state_q == ST_AR);
    assign in_r_s    = (state_q == ST_R);
    assign ar_fire_s = in_ar_s && own_arvalid_s && sram_arready;
    assign r_fire_s  = in_r_s && sram_rvalid && own_rready_s;

    // Next-state, owner, last-served and grant computation.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        grant_d = grant_q;
        case (state_q)
            ST_IDLE: begin
                if (ifu_arvalid || lsu_arvalid) begin
                    owner_d = rr_pick(ifu_arvalid, lsu_arvalid, last_q);
                    state_d = ST_AR;
                    grant_d = (owner_d == OWN_LSU) ? 2'b10 : 2'b01;
                end else begin
                    state_d = ST_IDLE;
                    grant_d = 2'b00;
                end
            end
            ST_AR: begin
                // The owner stays locked even if it drops arvalid; only the
                // address handshake moves the transaction forward.
                if (ar_fire_s) begin
                    state_d = ST_R;
                end else begin
                    state_d = ST_AR;
                end
            end
            ST_R: begin
                if (r_fire_s) begin
                    state_d = ST_IDLE;
                    last_d  = owner_q;
                    grant_d = 2'b00;
                end else begin
                    state_d = ST_R;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_IFU;
            last_q  <= OWN_LSU;
            grant_q <= 2'b00;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            grant_q <= grant_d;
        end
    end

    // Channel routing: only the owner is connected, and only in the matching phase.
    always_comb begin
        sram_araddr  = {ADDR_W{1'b0}};
        sram_arvalid = 1'b0;
        sram_rready  = 1'b0;
        ifu_arready  = 1'b0;
        lsu_arready  = 1'b0;
        ifu_rvalid   = 1'b0;
        lsu_rvalid   = 1'b0;
        ifu_rdata    = {DATA_W{1'b0}};
        lsu_rdata    = {DATA_W{1'b0}};
        if (in_ar_s) begin
            sram_araddr  = own_araddr_s;
            sram_arvalid = own_arvalid_s;
            if (owner_q == OWN_LSU) begin
                lsu_arready = sram_arready;
            end else begin
                ifu_arready = sram_arready;
            end
        end else if (in_r_s) begin
            sram_rready = own_rready_s;
            if (owner_q == OWN_LSU) begin
                lsu_rvalid = sram_rvalid;
                lsu_rdata  = sram_rdata;
            end else begin
                ifu_rvalid = sram_rvalid;
                ifu_rdata  = sram_rdata;
            end
        end else begin
            // Idle: everything stays at zero, so a late SRAM response is ignored.
            sram_rready = 1'b0;
        end
    end

    assign grant = grant_q;

endmodule
